cycle_counter: RTL
==================

// Module: cycle_counter
// PURPOSE
//  Parametrised WIDTH-bit up/down iteration counter with a start/busy/done
//  control FSM, programmable terminal value, parallel load and optional
//  auto-reload. Sequences multi-cycle datapath units (multiply/divide
//  iteration count) and general cycle timers in the processor.
// PARAMETERS
//  WIDTH        6   counter, limit and load_val width in bits (>=2)
//  AUTO_RELOAD  0   0 = one-shot (stop in DONE at terminal); 1 = reload, stay in RUN
// PORTS
//  clk       in   1      rising-edge clock
//  clr       in   1      synchronous active-high reset
//  en        in   1      count enable; 0 freezes count and FSM (start/load/clr still act)
//  start     in   1      begin/restart a run; samples limit and up
//  load      in   1      parallel load of count from load_val
//  load_val  in   WIDTH  load value
//  up        in   1      direction for next run: 1 = 0->limit, 0 = limit->0
//  limit     in   WIDTH  terminal value (up) / start value (down)
//  count     out  WIDTH  current count, registered
//  tc        out  1      terminal count: state==RUN && count==terminal (combinational)
//  busy      out  1      state==RUN
//  done      out  1      state==DONE
// BEHAVIOUR
//  - States IDLE, RUN, DONE. Regs: count, state, limit_q, dir_q.
//  - Priority each edge: clr > load > start > en-step.
//  - clr: count=0, state=IDLE, limit_q=0, dir_q=1; so busy=done=tc=0.
//  - load: count<=load_val; state, limit_q, dir_q unchanged; no step that cycle.
//  - start (any state): limit_q<=limit, dir_q<=up, count<=(up ? 0 : limit),
//    state<=RUN. start in RUN restarts.
//  - terminal = dir_q ? limit_q : 0. limit/up changes during a run are ignored.
//  - RUN, en=1, count!=terminal: count+1 (up) or count-1 (down), mod 2^WIDTH.
//  - RUN, en=1, count==terminal: one-shot -> state<=DONE, count held;
//    AUTO_RELOAD=1 -> count<=(dir_q ? 0 : limit_q), stay RUN.
//  - RUN, en=0: count and state held; tc may be high but takes no effect.
//  - IDLE and DONE: count held (only load/start/clr change it). DONE is held
//    until start or clr; load in DONE does not leave DONE.
//  - Latency: start at edge N, en=1 continuously -> tc high for the cycle after
//    edge N+limit; done rises after edge N+limit+1 (limit+1 enabled RUN cycles).
//  - limit=0: tc high in first RUN cycle; done after one enabled cycle.
//  - Load above terminal in up RUN: counts up, wraps 2^WIDTH-1 -> 0, continues
//    to limit_q. Load in down RUN: counts down to 0 from load_val.
//  - Mid-run clr returns to IDLE with count=0 on that edge; no done pulse.
// TESTING
//  1 WIDTH=6, one-shot, up=1, limit=5, start then en=1 -> count 0..5, tc at
//    count=5, done=1 and busy=0 next cycle, count holds 5 for 10 idle cycles.
//  2 up=0, limit=3, en toggled 1,0,1,0,... -> count 3,3,2,2,1,1,0 (en gaps hold);
//    done only after the enabled step at 0.
//  3 AUTO_RELOAD=1, up=1, limit=2, en=1 for 9 cycles -> 0,1,2,0,1,2,0,1,2,
//    tc every third cycle, done never asserts.
//  4 Run limit=10, change limit to 3 at count=4 -> continues to 10, done after 10;
//    limit=0 start -> tc first cycle, done after one en cycle.
//  5 clr mid-run at count=7 -> next cycle count=0, busy=done=tc=0; start+load
//    same cycle -> load_val wins, state unchanged.
//  6 WIDTH=4, up, limit=2, load_val=14 in RUN -> 14,15,0,1,2, then done.

Source files
------------

// File: rtl/cycle_counter.sv
// rtl/cycle_counter.sv - WIDTH-bit up/down iteration counter with IDLE/RUN/DONE control FSM
module cycle_counter #(
    parameter int WIDTH       = 6,
    parameter bit AUTO_RELOAD = 1'b0
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic             start,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             up,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] limit_q;
    logic             dir_q;
    logic [WIDTH-1:0] terminal;

    // Run parameters are captured at start so limit/up may change freely mid-run.
    assign terminal = dir_q ? limit_q : '0;
    assign tc       = (state == RUN) && (count == terminal);
    assign busy     = (state == RUN);
    assign done     = (state == DONE);

    always_ff @(posedge clk) begin
        if (clr) begin
            count   <= '0;
            state   <= IDLE;
            limit_q <= '0;
            dir_q   <= 1'b1;
        end else if (load) begin
            count <= load_val;
        end else if (start) begin
            limit_q <= limit;
            dir_q   <= up;
            count   <= up ? '0 : limit;
            state   <= RUN;
        end else if (en && (state == RUN)) begin
            if (count == terminal) begin
                if (AUTO_RELOAD) begin
                    count <= dir_q ? '0 : limit_q;
                end else begin
                    state <= DONE;
                end
            end else if (dir_q) begin
                count <= count + WIDTH'(1);
            end else begin
                count <= count - WIDTH'(1);
            end
        end
    end

endmodule
